// File: rtl/apb_resp_pkg.sv
// Shared types and constants for the apb_resp_regs APB3 completer:
// register offsets, FSM state enum, latched-transfer payload, decode helpers.
package apb_resp_pkg;

  localparam int unsigned ADDR_W    = 10;  // word address, paddr[11:2]
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned WAIT_W    = 4;   // WAITCFG field width
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned CNT_W     = 16;  // each STATUS counter

  // STATUS field positions
  localparam int unsigned STATUS_DONE_LSB = 0;
  localparam int unsigned STATUS_ERR_LSB  = 16;

  // Byte offsets
  localparam logic [11:0] REG0_OFF    = 12'h000;
  localparam logic [11:0] REG7_OFF    = 12'h01C;
  localparam logic [11:0] WAITCFG_OFF = 12'h020;
  localparam logic [11:0] STATUS_OFF  = 12'h024;
  localparam logic [11:0] ID_OFF      = 12'hFFC;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SEL_REG,
    SEL_WAITCFG,
    SEL_STATUS,
    SEL_ID,
    SEL_NONE
  } sel_e;

  // Transfer captured in the setup phase
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

  function automatic logic [ADDR_W-1:0] word_of(input logic [11:0] off);
    return off[11:2];
  endfunction

  function automatic logic [REG_IDX_W-1:0] reg_idx(input logic [ADDR_W-1:0] addr);
    return REG_IDX_W'(addr - word_of(REG0_OFF));
  endfunction

  // REG0 sits at word 0, so the block test only needs an upper bound
  function automatic sel_e decode(input logic [ADDR_W-1:0] addr);
    sel_e sel;
    if (addr <= word_of(REG7_OFF))           sel = SEL_REG;
    else if (addr == word_of(WAITCFG_OFF))   sel = SEL_WAITCFG;
    else if (addr == word_of(STATUS_OFF))    sel = SEL_STATUS;
    else if (addr == word_of(ID_OFF))        sel = SEL_ID;
    else                                     sel = SEL_NONE;
    return sel;
  endfunction

  // Unmapped offsets always error; read-only words error on write
  function automatic logic is_error(input sel_e sel, input logic write);
    return (sel == SEL_NONE) || (write && ((sel == SEL_STATUS) || (sel == SEL_ID)));
  endfunction

endpackage

// File: rtl/apb_resp_fsm.sv
// APB3 completer transfer sequencer: IDLE/ACCESS state, wait counter,
// setup-phase address/data latch, registered pready and completion strobe.
// Ports: pclkg/presetn; APB psel/penable/pwrite/paddr/pwdata in;
// waitcfg in (sampled at setup); xfer out (latched transfer);
// addr_nxt_c/write_nxt_c/pready_nxt_c out (values taking effect next edge,
// used by the top to register prdata/pslverr); pready out; complete_c out.
module apb_resp_fsm
  import apb_resp_pkg::*;
(
  input  logic              pclkg,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [WAIT_W-1:0] waitcfg,
  output xfer_t             xfer,
  output logic [ADDR_W-1:0] addr_nxt_c,
  output logic              write_nxt_c,
  output logic              pready_nxt_c,
  output logic              pready,
  output logic              complete_c
);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              setup_c;
  logic              abort_c;
  xfer_t             xfer_nxt_c;

  // Strobes and next-cycle transfer/pready
  always_comb begin
    setup_c      = (state == IDLE) && psel && !penable;
    complete_c   = (state == ACCESS) && psel && pready;
    abort_c      = (state == ACCESS) && !psel;
    xfer_nxt_c   = xfer;
    pready_nxt_c = 1'b0;
    if (setup_c) begin
      xfer_nxt_c.write = pwrite;
      xfer_nxt_c.addr  = paddr;
      xfer_nxt_c.wdata = pwdata;
      pready_nxt_c     = (waitcfg == '0);
    end else if ((state == ACCESS) && psel && !pready) begin
      // counter is still nonzero here; ready follows the last decrement
      pready_nxt_c = (wait_cnt == WAIT_W'(1));
    end
    addr_nxt_c  = xfer_nxt_c.addr;
    write_nxt_c = xfer_nxt_c.write;
  end

  // State, counter, latches
  always_ff @(posedge pclkg or negedge presetn) begin
    if (!presetn) begin
      state    <= IDLE;
      wait_cnt <= '0;
      xfer     <= '0;
      pready   <= 1'b0;
    end else begin
      xfer   <= xfer_nxt_c;
      pready <= pready_nxt_c;
      case (state)
        IDLE: begin
          if (setup_c) begin
            state    <= ACCESS;
            wait_cnt <= waitcfg;
          end
        end
        ACCESS: begin
          if (abort_c || complete_c) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/apb_resp_regs.sv
// APB3 completer with eight RW registers, programmable wait states (WAITCFG),
// transfer/error counters (STATUS) and an ID word; drives every pready/pslverr
// case a requester has to handle.
// Ports: pclkg, presetn (async active-low); psel, penable, pwrite,
// paddr[11:2], pwdata[31:0] in; prdata[31:0], pready, pslverr out (all
// registered, zero unless pready=1).
// DONE_PRELOAD/ERR_PRELOAD set the STATUS counter reset values (default 0).
module apb_resp_regs
  import apb_resp_pkg::*;
#(
  parameter logic [DATA_W-1:0] ID_VALUE     = 32'h0001_A0B5,
  parameter logic [WAIT_W-1:0] WAIT_DEFAULT = 4'd0,
  parameter logic [CNT_W-1:0]  DONE_PRELOAD = 16'h0000,
  parameter logic [CNT_W-1:0]  ERR_PRELOAD  = 16'h0000
) (
  input  logic              pclkg,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [11:2]       paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  xfer_t             xfer;
  logic [ADDR_W-1:0] addr_nxt_c;
  logic              write_nxt_c;
  logic              pready_nxt_c;
  logic              complete_c;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [WAIT_W-1:0] waitcfg;
  logic [CNT_W-1:0]  done_cnt;
  logic [CNT_W-1:0]  err_cnt;

  sel_e              sel_nxt_c;
  sel_e              sel_c;
  logic              err_nxt_c;
  logic              wr_en_c;
  logic [DATA_W-1:0] rdata_nxt_c;

  apb_resp_fsm u_fsm (
    .pclkg        (pclkg),
    .presetn      (presetn),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .waitcfg      (waitcfg),
    .xfer         (xfer),
    .addr_nxt_c   (addr_nxt_c),
    .write_nxt_c  (write_nxt_c),
    .pready_nxt_c (pready_nxt_c),
    .pready       (pready),
    .complete_c   (complete_c)
  );

  // Response for the cycle in which pready will be high; STATUS is sampled
  // before this transfer's own increment
  always_comb begin
    sel_nxt_c   = decode(addr_nxt_c);
    err_nxt_c   = is_error(sel_nxt_c, write_nxt_c);
    rdata_nxt_c = '0;
    if (pready_nxt_c && !write_nxt_c && !err_nxt_c) begin
      case (sel_nxt_c)
        SEL_REG:     rdata_nxt_c = regs[reg_idx(addr_nxt_c)];
        SEL_WAITCFG: rdata_nxt_c = DATA_W'(waitcfg);
        SEL_STATUS: begin
          rdata_nxt_c[STATUS_DONE_LSB +: CNT_W] = done_cnt;
          rdata_nxt_c[STATUS_ERR_LSB +: CNT_W]  = err_cnt;
        end
        SEL_ID:      rdata_nxt_c = ID_VALUE;
        default:     rdata_nxt_c = '0;
      endcase
    end
  end

  // Commit decode from the latched transfer
  always_comb begin
    sel_c   = decode(xfer.addr);
    wr_en_c = complete_c && xfer.write && !pslverr;
  end

  // Register bank, counters and registered response
  always_ff @(posedge pclkg or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      waitcfg  <= WAIT_DEFAULT;
      done_cnt <= DONE_PRELOAD;
      err_cnt  <= ERR_PRELOAD;
      prdata   <= '0;
      pslverr  <= 1'b0;
    end else begin
      prdata  <= rdata_nxt_c;
      pslverr <= pready_nxt_c && err_nxt_c;
      if (wr_en_c) begin
        case (sel_c)
          SEL_REG:     regs[reg_idx(xfer.addr)] <= xfer.wdata;
          SEL_WAITCFG: waitcfg <= xfer.wdata[WAIT_W-1:0];
          default:     ;
        endcase
      end
      if (complete_c) begin
        done_cnt <= done_cnt + CNT_W'(1);  // wraps
        if (pslverr && (err_cnt != '1)) begin
          err_cnt <= err_cnt + CNT_W'(1);  // saturates
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_resp_regs.sv
// Self-checking bench for apb_resp_regs: directed vector table, hand-written
// abort/reset/idle/saturation sequences, and randomized transfers checked
// against an array-based model of the register map.
module tb_apb_resp_regs;

  logic        pclkg;
  logic        presetn;
  logic        psel;
  logic        psel2;
  logic        penable;
  logic        pwrite;
  logic [11:2] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata,  prdata2;
  logic        pready,  pready2;
  logic        pslverr, pslverr2;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] ID_VAL = 32'h0001_A0B5;

  apb_resp_regs u_dut (
    .pclkg   (pclkg),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  // Counters preloaded near their limits for wrap/saturation
  apb_resp_regs #(
    .DONE_PRELOAD (16'hFFFE),
    .ERR_PRELOAD  (16'hFFFE)
  ) u_sat (
    .pclkg   (pclkg),
    .presetn (presetn),
    .psel    (psel2),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata2),
    .pready  (pready2),
    .pslverr (pslverr2)
  );

  initial pclkg = 1'b0;
  always #5 pclkg = ~pclkg;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [31:0] m_regs [8];
  int          m_wait;
  int          m_done;
  int          m_err;

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
    m_wait = 0;
    m_done = 0;
    m_err  = 0;
  endfunction

  // Predict one completed transfer, then update the model
  function automatic void m_step(input bit w, input logic [11:0] off, input logic [31:0] d,
                                 output logic [31:0] rd, output bit err, output int waits);
    bit mapped;
    bit ro;
    mapped = (off <= 12'h024) || (off == 12'hFFC);
    ro     = (off == 12'h024) || (off == 12'hFFC);
    err    = !mapped || (w && ro);
    waits  = m_wait;
    rd     = 32'h0;
    if (!w && !err) begin
      if (off < 12'h020)       rd = m_regs[off / 4];
      else if (off == 12'h020) rd = 32'(m_wait);
      else if (off == 12'h024) rd = {m_err[15:0], m_done[15:0]};
      else                     rd = ID_VAL;
    end
    if (w && !err) begin
      if (off < 12'h020)       m_regs[off / 4] = d;
      else if (off == 12'h020) m_wait = int'(d % 16);
    end
    m_done = (m_done + 1) % 65536;
    if (err && m_err < 65535) m_err = m_err + 1;
  endfunction

  // ---------------- checking helpers ----------------
  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // One APB transfer; call just after a rising edge. Leaves the bus idle so a
  // following call issues its setup on the very next cycle.
  task automatic xfer(input bit tgt, input bit w, input logic [11:0] off, input logic [31:0] d,
                      output logic [31:0] rd, output bit err, output int waits, output bit to);
    bit done;
    done  = 0;
    rd    = 32'h0;
    err   = 0;
    waits = 0;
    to    = 0;
    psel    = !tgt;
    psel2   = tgt;
    penable = 1'b0;
    pwrite  = w;
    paddr   = off[11:2];
    pwdata  = d;
    @(posedge pclkg); #1;
    penable = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge pclkg);
      if (tgt ? pready2 : pready) begin
        rd   = tgt ? prdata2 : prdata;
        err  = tgt ? pslverr2 : pslverr;
        done = 1;
      end else begin
        waits++;
        check("wait-cycle prdata", tgt ? prdata2 : prdata, 32'h0);
        check("wait-cycle pslverr", 32'(tgt ? pslverr2 : pslverr), 32'h0);
      end
      @(posedge pclkg); #1;
    end
    if (!done) begin
      to = 1;
      n_cmp++;
      n_bad++;
      $display("FAIL pready timeout at offset %h: got no pready expected pready within 40 cycles", off);
    end
    psel    = 1'b0;
    psel2   = 1'b0;
    penable = 1'b0;
  endtask

  task automatic run(input bit tgt, input bit w, input logic [11:0] off, input logic [31:0] d,
                     input logic [31:0] exp_rd, input bit exp_err, input int exp_waits,
                     input string nm);
    logic [31:0] rd;
    bit          err;
    int          waits;
    bit          to;
    xfer(tgt, w, off, d, rd, err, waits, to);
    if (!to) begin
      check({nm, " waits"}, 32'(waits), 32'(exp_waits));
      check({nm, " pslverr"}, 32'(err), 32'(exp_err));
      if (!w) check({nm, " prdata"}, rd, exp_rd);
    end
  endtask

  // Transfer on the main DUT with expectations from the model
  task automatic run_model(input bit w, input logic [11:0] off, input logic [31:0] d,
                           input string nm);
    logic [31:0] rd;
    bit          err;
    int          waits;
    m_step(w, off, d, rd, err, waits);
    run(1'b0, w, off, d, rd, err, waits, nm);
  endtask

  typedef struct {
    bit          w;
    logic [11:0] off;
    logic [31:0] d;
    logic [31:0] rd;
    bit          err;
    int          waits;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [31:0] rd_dummy;
    bit          err_dummy;
    int          w_dummy;
    bit          rw;
    int          k;
    logic [11:0] off;
    logic [31:0] d;

    vecs[0]  = '{1'b1, 12'h004, 32'hDEADBEEF, 32'h0,          1'b0, 0};
    vecs[1]  = '{1'b0, 12'h004, 32'h0,        32'hDEADBEEF,   1'b0, 0};
    vecs[2]  = '{1'b0, 12'h024, 32'h0,        32'h0000_0002,  1'b0, 0};
    vecs[3]  = '{1'b1, 12'h020, 32'h3,        32'h0,          1'b0, 0};
    vecs[4]  = '{1'b0, 12'hFFC, 32'h0,        32'h0001_A0B5,  1'b0, 3};
    vecs[5]  = '{1'b0, 12'h100, 32'h0,        32'h0,          1'b1, 3};
    vecs[6]  = '{1'b1, 12'h024, 32'h1234_5678, 32'h0,         1'b1, 3};
    vecs[7]  = '{1'b0, 12'h024, 32'h0,        32'h0002_0007,  1'b0, 3};
    vecs[8]  = '{1'b1, 12'h020, 32'h0,        32'h0,          1'b0, 3};
    vecs[9]  = '{1'b0, 12'h020, 32'h0,        32'h0,          1'b0, 0};
    vecs[10] = '{1'b1, 12'hFFC, 32'h1,        32'h0,          1'b1, 0};
    vecs[11] = '{1'b0, 12'h000, 32'h0,        32'h0,          1'b0, 0};
    vecs[12] = '{1'b0, 12'h024, 32'h0,        32'h0003_000C,  1'b0, 0};

    presetn = 1'b0;
    psel    = 1'b0;
    psel2   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    m_reset();
    repeat (2) @(posedge pclkg);
    @(negedge pclkg);
    check("reset pready", 32'(pready), 32'h0);
    check("reset pslverr", 32'(pslverr), 32'h0);
    check("reset prdata", prdata, 32'h0);
    presetn = 1'b1;
    @(posedge pclkg); #1;

    // Directed vectors, back to back
    for (int i = 0; i < 13; i++) begin
      m_step(vecs[i].w, vecs[i].off, vecs[i].d, rd_dummy, err_dummy, w_dummy);
      run(1'b0, vecs[i].w, vecs[i].off, vecs[i].d, vecs[i].rd, vecs[i].err, vecs[i].waits,
          $sformatf("vec%0d", i));
    end

    // penable without setup is ignored
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 10'h001;
    pwdata  = 32'hBAD0_BAD0;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclkg);
      check("no-setup pready", 32'(pready), 32'h0);
      @(posedge pclkg); #1;
    end
    psel    = 1'b0;
    penable = 1'b0;
    run_model(1'b0, 12'h004, 32'h0, "no-setup reg1");
    run_model(1'b0, 12'h024, 32'h0, "no-setup status");

    // Abort on the 2nd access cycle of a 5-wait write
    run_model(1'b1, 12'h020, 32'h5, "wait5 set");
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 10'h002;
    pwdata  = 32'hAAAA_5555;
    @(posedge pclkg); #1;
    penable = 1'b1;
    @(negedge pclkg);
    check("abort access1 pready", 32'(pready), 32'h0);
    @(posedge pclkg); #1;
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge pclkg);
    check("abort pready", 32'(pready), 32'h0);
    @(posedge pclkg); #1;
    run_model(1'b0, 12'h008, 32'h0, "abort reg2");
    run_model(1'b0, 12'h024, 32'h0, "abort status");

    // Reset in the middle of a waited write
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 10'h003;
    pwdata  = 32'h1111_2222;
    @(posedge pclkg); #1;
    penable = 1'b1;
    repeat (2) @(posedge pclkg);
    @(negedge pclkg);
    #2 presetn = 1'b0;
    #1;
    check("midreset pready", 32'(pready), 32'h0);
    check("midreset pslverr", 32'(pslverr), 32'h0);
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge pclkg);
    presetn = 1'b1;
    m_reset();
    @(posedge pclkg); #1;

    // Reset while a read response is on the bus clears it without a clock edge
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 10'h3FF;
    @(posedge pclkg); #1;
    penable = 1'b1;
    @(negedge pclkg);
    check("id pready", 32'(pready), 32'h1);
    check("id prdata", prdata, ID_VAL);
    #2 presetn = 1'b0;
    #1;
    check("async reset pready", 32'(pready), 32'h0);
    check("async reset prdata", prdata, 32'h0);
    check("async reset pslverr", 32'(pslverr), 32'h0);
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge pclkg);
    presetn = 1'b1;
    m_reset();
    @(posedge pclkg); #1;
    run(1'b0, 1'b0, 12'h00C, 32'h0, 32'h0, 1'b0, 0, "post-reset reg3");
    run(1'b0, 1'b0, 12'h020, 32'h0, 32'h0, 1'b0, 0, "post-reset waitcfg");
    run(1'b0, 1'b0, 12'h024, 32'h0, 32'h0000_0002, 1'b0, 0, "post-reset status");
    m_done = 3;

    // Counter wrap and saturation on the preloaded instance
    run(1'b1, 1'b0, 12'h100, 32'h0, 32'h0, 1'b1, 0, "sat err1");
    run(1'b1, 1'b1, 12'hFFC, 32'h5, 32'h0, 1'b1, 0, "sat err2");
    run(1'b1, 1'b0, 12'h024, 32'h0, 32'hFFFF_0000, 1'b0, 0, "sat wrap status");
    run(1'b1, 1'b0, 12'h800, 32'h0, 32'h0, 1'b1, 0, "sat err3");
    run(1'b1, 1'b0, 12'h024, 32'h0, 32'hFFFF_0002, 1'b0, 0, "sat hold status");

    // Randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      rw = 1'($urandom_range(0, 1));
      k  = int'($urandom_range(0, 9));
      d  = $urandom;
      if (k <= 4)      off = 12'($urandom_range(0, 7) * 4);
      else if (k == 5) begin
        off = 12'h020;
        d   = 32'($urandom_range(0, 6));
      end
      else if (k == 6) off = 12'h024;
      else if (k == 7) off = 12'hFFC;
      else             off = 12'($urandom_range(10, 1022) * 4);
      run_model(rw, off, d, $sformatf("rand%0d off=%h", i, off));
    end
    run_model(1'b0, 12'h024, 32'h0, "final status");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
